ixc_mc_ififo_ack_ctl: RTL and testbench

//  Credit-return scheduler for the MC input FIFO. Counts words drained from the FIFO
//  and batches them into ack credits (ackClk toggle + ackLen) for the producer side.

---
 rtl/ixc_mc_ififo_pkg.sv | 22 ++
 rtl/ixc_mc_ack_timer.sv | 24 ++
 rtl/ixc_mc_ififo_ack_ctl.sv | 116 +++++++++++
 tb/tb_ixc_mc_ififo_ack_ctl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ixc_mc_ififo_pkg.sv
// ixc_mc_ififo_pkg: shared types, widths and default parameters for the MC input FIFO ack controller
package ixc_mc_ififo_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_INIT_ACK  = 2'd1,
        ST_RUN       = 2'd2,
        ST_HOLD      = 2'd3
    } state_e;

    localparam int ACK_LEN_W = 18;
    localparam int PTR_W     = 17;
    localparam int RDLEN_W   = 4;
    localparam int TMR_W     = 12;
    localparam int HOLD_W    = 8;

    localparam int DEPTH_DEF  = 131072;
    localparam int THRESH_DEF = 256;
    localparam int TMO_DEF    = 1024;
    localparam int HOLD_DEF   = 4;

endpackage

// File: rtl/ixc_mc_ack_timer.sv
// ixc_mc_ack_timer: idle counter that flags when pending credit has waited TMO cycles
module ixc_mc_ack_timer
    import ixc_mc_ififo_pkg::*;
#(
    parameter int TMO = TMO_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic clr_i,
    output logic expire_o
);

    logic [TMR_W-1:0] cnt_q;

    // count idle cycles; clear has priority over counting
    always_ff @(posedge clk) begin
        if (rst || clr_i) cnt_q <= '0;
        else if (run_i)   cnt_q <= cnt_q + TMR_W'(1);
    end

    assign expire_o = cnt_q == TMR_W'(TMO - 1);

endmodule

// File: rtl/ixc_mc_ififo_ack_ctl.sv
// ixc_mc_ififo_ack_ctl: batches drained FIFO words into toggle-type ack credits
module ixc_mc_ififo_ack_ctl
    import ixc_mc_ififo_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int THRESH = THRESH_DEF,
    parameter int TMO    = TMO_DEF,
    parameter int HOLD   = HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rst_done_i,
    input  logic                 rd_adv_i,
    input  logic [RDLEN_W-1:0]   rd_len_i,
    input  logic                 flush_i,
    output logic                 ack_clk_o,
    output logic [ACK_LEN_W-1:0] ack_len_o,
    output logic                 ack_busy_o,
    output logic [ACK_LEN_W-1:0] pend_cnt_o,
    output logic                 ovf_err_o
);

    localparam logic [ACK_LEN_W:0] DEPTH_X  = (ACK_LEN_W+1)'(DEPTH);
    localparam logic [ACK_LEN_W:0] THRESH_X = (ACK_LEN_W+1)'(THRESH);
    localparam logic [HOLD_W-1:0]  HOLD_LD  = HOLD_W'(HOLD - 1);

    state_e               state_q, state_d;
    logic [ACK_LEN_W-1:0] pend_q, pend_d, len_q, len_d, pend_sat;
    logic [ACK_LEN_W:0]   pend_next;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 ack_q, ack_d, busy_q, ovf_q, ovf_d, fp_q, fp_d;
    logic                 in_run, ovf, fire, expire;

    assign in_run    = state_q == ST_RUN;
    assign pend_next = {1'b0, pend_q} + (ACK_LEN_W+1)'(rd_adv_i ? rd_len_i : '0);
    assign ovf       = pend_next > DEPTH_X;
    assign pend_sat  = ovf ? DEPTH_X[ACK_LEN_W-1:0] : pend_next[ACK_LEN_W-1:0];
    assign fire      = in_run && (pend_next >= THRESH_X
                                  || (expire && pend_q != '0)
                                  || ((flush_i || fp_q) && pend_next != '0));

    ixc_mc_ack_timer #(.TMO(TMO)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .run_i    (in_run && pend_q != '0 && !fire),
        .clr_i    (in_run && (pend_q == '0 || fire)),
        .expire_o (expire)
    );

    // next-state: init advertisement, accumulation with saturation, fire and hold pacing
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        len_d   = len_q;
        ack_d   = ack_q;
        hold_d  = hold_q;
        ovf_d   = ovf_q;
        fp_d    = fp_q;
        if (state_q == ST_WAIT_INIT) begin
            state_d = rst_done_i ? ST_INIT_ACK : ST_WAIT_INIT;
        end else if (state_q == ST_INIT_ACK) begin
            len_d   = ACK_LEN_W'(DEPTH);
            ack_d   = !ack_q;
            hold_d  = HOLD_LD;
            fp_d    = fp_q || flush_i;
            state_d = ST_HOLD;
        end else begin
            pend_d = pend_sat;
            ovf_d  = ovf_q || ovf;
            if (state_q == ST_HOLD) begin
                fp_d    = fp_q || flush_i;
                hold_d  = hold_q - HOLD_W'(1);
                state_d = hold_q == '0 ? ST_RUN : ST_HOLD;
            end else begin
                fp_d = 1'b0;
                if (fire) begin
                    len_d   = pend_sat;
                    pend_d  = '0;
                    ack_d   = !ack_q;
                    hold_d  = HOLD_LD;
                    state_d = ST_HOLD;
                end
            end
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WAIT_INIT;
            pend_q  <= '0;
            len_q   <= '0;
            ack_q   <= 1'b0;
            hold_q  <= '0;
            ovf_q   <= 1'b0;
            fp_q    <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            len_q   <= len_d;
            ack_q   <= ack_d;
            hold_q  <= hold_d;
            ovf_q   <= ovf_d;
            fp_q    <= fp_d;
            busy_q  <= state_d != ST_RUN;
        end
    end

    assign ack_clk_o  = ack_q;
    assign ack_len_o  = len_q;
    assign ack_busy_o = busy_q;
    assign pend_cnt_o = pend_q;
    assign ovf_err_o  = ovf_q;

endmodule

// File: tb/tb_ixc_mc_ififo_ack_ctl.sv
// tb_ixc_mc_ififo_ack_ctl: directed, table-driven and randomized checks of the ack controller
module tb_ixc_mc_ififo_ack_ctl;

    localparam int TMO  = 1024;
    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst, rst6, rst_done, rd_adv, flush;
    logic [3:0]  rd_len;
    logic        ack_clk [2];
    logic [17:0] ack_len [2];
    logic        busy    [2];
    logic [17:0] pend    [2];
    logic        ovf     [2];

    int checks = 0;
    int errors = 0;

    // reference model state: ph -2 waiting for init, -1 init ack, >0 hold cycles left, 0 running
    int ph [2], pn [2], idl [2], ml [2];
    bit mc [2], mo [2], fp [2];
    int dep [2] = '{131072, 64};
    int thr [2] = '{256, 128};

    typedef struct {
        bit adv;
        int len;
        bit fl;
        bit tog;
        int elen;
        int epend;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;

    ixc_mc_ififo_ack_ctl dut (
        .clk(clk), .rst(rst), .rst_done_i(rst_done), .rd_adv_i(rd_adv), .rd_len_i(rd_len),
        .flush_i(flush), .ack_clk_o(ack_clk[0]), .ack_len_o(ack_len[0]), .ack_busy_o(busy[0]),
        .pend_cnt_o(pend[0]), .ovf_err_o(ovf[0])
    );

    ixc_mc_ififo_ack_ctl #(.DEPTH(64), .THRESH(128), .TMO(TMO), .HOLD(HOLD)) dut6 (
        .clk(clk), .rst(rst6), .rst_done_i(rst_done), .rd_adv_i(rd_adv), .rd_len_i(rd_len),
        .flush_i(flush), .ack_clk_o(ack_clk[1]), .ack_len_o(ack_len[1]), .ack_busy_o(busy[1]),
        .pend_cnt_o(pend[1]), .ovf_err_o(ovf[1])
    );

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_step(int i, logic r);
        int p;
        bit fire;
        if (r) begin
            ph[i] = -2; pn[i] = 0; idl[i] = 0; fp[i] = 0; mc[i] = 0; ml[i] = 0; mo[i] = 0;
            return;
        end
        if (ph[i] == -2) begin
            if (rst_done) ph[i] = -1;
        end else if (ph[i] == -1) begin
            ml[i] = dep[i]; mc[i] = !mc[i]; fp[i] = fp[i] | flush; ph[i] = HOLD;
        end else begin
            p = pn[i] + (rd_adv ? int'(rd_len) : 0);
            if (p > dep[i]) begin p = dep[i]; mo[i] = 1; end
            if (ph[i] > 0) begin
                pn[i] = p; fp[i] = fp[i] | flush; ph[i]--;
            end else begin
                fire = p >= thr[i] || (idl[i] == TMO - 1 && pn[i] != 0) || ((flush || fp[i]) && p != 0);
                fp[i] = 0;
                if (fire) begin
                    ml[i] = p; mc[i] = !mc[i]; pn[i] = 0; idl[i] = 0; ph[i] = HOLD;
                end else begin
                    idl[i] = pn[i] != 0 ? idl[i] + 1 : 0;
                    pn[i] = p;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, rst);
        model_step(1, rst6);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("model%0d.ack_clk", i), int'(ack_clk[i]), int'(mc[i]));
            chk($sformatf("model%0d.ack_len", i), int'(ack_len[i]), ml[i]);
            chk($sformatf("model%0d.busy", i), int'(busy[i]), int'(ph[i] != 0));
            chk($sformatf("model%0d.pend", i), int'(pend[i]), pn[i]);
            chk($sformatf("model%0d.ovf", i), int'(ovf[i]), int'(mo[i]));
        end
    endtask

    task automatic add(bit adv, int len, bit fl, bit tog, int elen, int epend);
        vec_t v;
        v.adv = adv; v.len = len; v.fl = fl; v.tog = tog; v.elen = elen; v.epend = epend;
        tv.push_back(v);
    endtask

    initial begin
        int  n;
        bit  prev;
        bit  dense;
        rst = 1; rst6 = 1; rst_done = 0; rd_adv = 0; rd_len = 0; flush = 0;

        // T1: init advertisement
        repeat (3) tick();
        rst = 0;
        tick();
        chk("t1.rst_clk", int'(ack_clk[0]), 0);
        chk("t1.rst_len", int'(ack_len[0]), 0);
        chk("t1.rst_busy", int'(busy[0]), 1);
        chk("t1.rst_pend", int'(pend[0]), 0);
        chk("t1.rst_ovf", int'(ovf[0]), 0);
        rst_done = 1;
        tick();
        chk("t1.init_ack_clk", int'(ack_clk[0]), 0);
        tick();
        chk("t1.toggle", int'(ack_clk[0]), 1);
        chk("t1.len", int'(ack_len[0]), 131072);
        chk("t1.busy_hold0", int'(busy[0]), 1);
        for (int k = 1; k < HOLD; k++) begin
            tick();
            chk($sformatf("t1.busy_hold%0d", k), int'(busy[0]), 1);
        end
        tick();
        chk("t1.busy_run", int'(busy[0]), 0);

        // T2: threshold crossing
        rd_adv = 1; rd_len = 8;
        repeat (31) tick();
        chk("t2.pend31", int'(pend[0]), 248);
        chk("t2.no_early", int'(ack_clk[0]), 1);
        tick();
        rd_adv = 0; rd_len = 0;
        chk("t2.toggle", int'(ack_clk[0]), 0);
        chk("t2.len", int'(ack_len[0]), 256);
        chk("t2.pend", int'(pend[0]), 0);
        repeat (10) tick();
        chk("t2.quiet", int'(ack_clk[0]), 0);

        // T3: idle timeout
        rd_adv = 1; rd_len = 3;
        tick();
        rd_adv = 0; rd_len = 0;
        n = 0;
        do begin tick(); n++; end while (ack_clk[0] == 1'b0 && n < 1100);
        chk("t3.latency", n, 1024);
        chk("t3.len", int'(ack_len[0]), 3);
        repeat (1100) tick();
        chk("t3.quiet", int'(ack_clk[0]), 1);

        // T4: threshold then traffic during HOLD; T5: flush cases (table-driven)
        rd_adv = 1; rd_len = 8;
        repeat (32) tick();
        chk("t4.toggle", int'(ack_clk[0]), 0);
        chk("t4.len", int'(ack_len[0]), 256);
        add(1, 8, 0, 0, 256, 8);
        add(1, 8, 0, 0, 256, 16);
        add(1, 8, 0, 0, 256, 24);
        add(1, 8, 0, 0, 256, 32);
        add(0, 0, 0, 0, 256, 32);
        add(0, 0, 1, 1, 32, 0);
        repeat (HOLD) add(0, 0, 0, 0, 32, 0);
        add(1, 5, 0, 0, 32, 5);
        add(0, 0, 1, 1, 5, 0);
        add(1, 2, 0, 0, 5, 2);
        add(0, 0, 1, 0, 5, 2);
        add(0, 0, 0, 0, 5, 2);
        add(0, 0, 0, 0, 5, 2);
        add(0, 0, 0, 1, 2, 0);
        repeat (HOLD) add(0, 0, 0, 0, 2, 0);
        add(0, 0, 1, 0, 2, 0);
        add(0, 0, 0, 0, 2, 0);
        add(1, 1, 0, 0, 2, 1);
        add(0, 0, 0, 0, 2, 1);
        foreach (tv[k]) begin
            prev = ack_clk[0];
            rd_adv = tv[k].adv; rd_len = 4'(tv[k].len); flush = tv[k].fl;
            tick();
            chk($sformatf("tbl%0d.tog", k), int'(ack_clk[0] ^ prev), int'(tv[k].tog));
            chk($sformatf("tbl%0d.len", k), int'(ack_len[0]), tv[k].elen);
            chk($sformatf("tbl%0d.pend", k), int'(pend[0]), tv[k].epend);
        end
        rd_adv = 0; rd_len = 0; flush = 1;
        tick();
        flush = 0;
        repeat (HOLD) tick();

        // T6: overflow and reset mid-HOLD on the small instance
        rst6 = 0;
        tick();
        tick();
        chk("t6.init_len", int'(ack_len[1]), 64);
        repeat (HOLD) tick();
        rd_adv = 1; rd_len = 8;
        repeat (9) tick();
        rd_adv = 0; rd_len = 0;
        chk("t6.pend_sat", int'(pend[1]), 64);
        chk("t6.ovf", int'(ovf[1]), 1);
        flush = 1;
        tick();
        flush = 0;
        tick();
        chk("t6.in_hold", int'(busy[1]), 1);
        rst6 = 1;
        tick();
        chk("t6.rst_clk", int'(ack_clk[1]), 0);
        chk("t6.rst_len", int'(ack_len[1]), 0);
        chk("t6.rst_ovf", int'(ovf[1]), 0);
        chk("t6.rst_pend", int'(pend[1]), 0);
        chk("t6.rst_busy", int'(busy[1]), 1);
        rst6 = 0; rst_done = 0; rd_adv = 1; rd_len = 8;
        repeat (3) tick();
        chk("t6.wait_clk", int'(ack_clk[1]), 0);
        chk("t6.wait_pend", int'(pend[1]), 0);
        rd_adv = 0; rd_len = 0;

        // randomized traffic against the reference model
        dense = 1;
        for (int c = 0; c < 5000; c++) begin
            if (c % 250 == 0) dense = $urandom_range(0, 1) == 1;
            rst      = $urandom_range(0, 999) == 0;
            rst6     = $urandom_range(0, 999) == 0;
            rst_done = $urandom_range(0, 9) != 0;
            rd_adv   = dense ? $urandom_range(0, 1) == 1 : $urandom_range(0, 299) == 0;
            rd_len   = 4'($urandom_range(0, 8));
            flush    = $urandom_range(0, 63) == 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
